// File: rtl/tri_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : tri_mux_arbiter_pkg
// Brief  : Shared select codes, FSM encoding and select decode for the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package tri_mux_arbiter_pkg;

  localparam logic signed [2:0] SEL_IN1  = 3'sd2;
  localparam logic signed [2:0] SEL_IN2  = -3'sd2;
  localparam logic signed [2:0] SEL_ZERO = 3'sd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_e;

  function automatic logic signed [2:0] state_to_sel(input state_e s);
    case (s)
      ST_GRANT_A: return SEL_IN1;
      ST_GRANT_B: return SEL_IN2;
      default:    return SEL_ZERO;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tri_mux_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module : tri_mux_arbiter_mux
// Brief  : Signed three-way mux: +2 selects in1, -2 selects in2, else zero.
// Rev    : 1.0 - initial release
// ============================================================================
module tri_mux_arbiter_mux
  import tri_mux_arbiter_pkg::*;
#(
  parameter int BITS = 7
) (
  input  logic signed [2:0]      i_sel,
  input  logic signed [BITS-1:0] i_in1,
  input  logic signed [BITS-1:0] i_in2,
  output logic signed [BITS-1:0] o_out
);

  always_comb begin
    case (i_sel)
      SEL_IN1: o_out = i_in1;
      SEL_IN2: o_out = i_in2;
      default: o_out = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tri_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tri_mux_arbiter
// Brief  : Round-robin two-requester arbiter with burst limit feeding a
//          single-entry registered output stage through a signed 3-way mux.
// Rev    : 1.0 - initial release
// ============================================================================
module tri_mux_arbiter
  import tri_mux_arbiter_pkg::*;
#(
  parameter int BITS      = 7,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_a_valid,
  input  logic signed [BITS-1:0] req_a_data,
  output logic                   req_a_ready,
  input  logic                   req_b_valid,
  input  logic signed [BITS-1:0] req_b_data,
  output logic                   req_b_ready,
  output logic signed [2:0]      select,
  output logic                   out_valid,
  output logic signed [BITS-1:0] out_data,
  input  logic                   out_ready
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] C_BURST_LAST = BURST_W'(MAX_BURST - 1);

  state_e                 r_state;
  logic [BURST_W-1:0]     r_burst;
  logic                   r_last_b;
  logic                   r_out_valid;
  logic signed [BITS-1:0] r_out_data;

  logic                   w_load_en;
  logic                   w_xfer_a;
  logic                   w_xfer_b;
  logic                   w_xfer;
  logic signed [BITS-1:0] w_mux_out;

  assign select      = state_to_sel(r_state);
  assign w_load_en   = !r_out_valid || out_ready;
  assign req_a_ready = (r_state == ST_GRANT_A) && w_load_en;
  assign req_b_ready = (r_state == ST_GRANT_B) && w_load_en;
  assign w_xfer_a    = req_a_valid && req_a_ready;
  assign w_xfer_b    = req_b_valid && req_b_ready;
  assign w_xfer      = w_xfer_a || w_xfer_b;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;

  tri_mux_arbiter_mux #(
    .BITS (BITS)
  ) u_mux (
    .i_sel (select),
    .i_in1 (req_a_data),
    .i_in2 (req_b_data),
    .o_out (w_mux_out)
  );

  // Every entry into a grant restarts the burst and records the winner,
  // so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_burst  <= '0;
      r_last_b <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_a_valid && (!req_b_valid || r_last_b)) begin
            r_state  <= ST_GRANT_A;
            r_burst  <= '0;
            r_last_b <= 1'b0;
          end else if (req_b_valid) begin
            r_state  <= ST_GRANT_B;
            r_burst  <= '0;
            r_last_b <= 1'b1;
          end
        end
        ST_GRANT_A: begin
          if (!req_a_valid) begin
            if (req_b_valid) begin
              r_state  <= ST_GRANT_B;
              r_burst  <= '0;
              r_last_b <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_xfer_a) begin
            if (r_burst == C_BURST_LAST) begin
              if (req_b_valid) begin
                r_state  <= ST_GRANT_B;
                r_last_b <= 1'b1;
              end
              r_burst <= '0;
            end else begin
              r_burst <= r_burst + BURST_W'(1);
            end
          end
        end
        ST_GRANT_B: begin
          if (!req_b_valid) begin
            if (req_a_valid) begin
              r_state  <= ST_GRANT_A;
              r_burst  <= '0;
              r_last_b <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_xfer_b) begin
            if (r_burst == C_BURST_LAST) begin
              if (req_a_valid) begin
                r_state  <= ST_GRANT_A;
                r_last_b <= 1'b0;
              end
              r_burst <= '0;
            end else begin
              r_burst <= r_burst + BURST_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_burst <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      r_out_data  <= w_xfer ? w_mux_out : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_tri_mux_arbiter
// Brief  : Scoreboard bench for tri_mux_arbiter with directed and random traffic.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tri_mux_arbiter;

  localparam int BITS = 7;
  localparam int MAXB = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_a_valid, req_a_ready;
  logic signed [BITS-1:0] req_a_data;
  logic                   req_b_valid, req_b_ready;
  logic signed [BITS-1:0] req_b_data;
  logic signed [2:0]      select;
  logic                   out_valid;
  logic signed [BITS-1:0] out_data;
  logic                   out_ready;

  tri_mux_arbiter #(.BITS(BITS), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
    .select(select), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  logic signed [BITS-1:0] src_a[$], src_b[$];
  logic signed [BITS-1:0] exp_q[$];
  logic signed [BITS-1:0] out_log[$];
  int                     out_cyc[$];
  logic signed [BITS-1:0] ma[$], mb[$], ord_q[$];
  int gap_pct    = 0;
  int ordy_pct   = 100;
  int stall_lo   = -1;
  int stall_hi   = -1;
  int a_rise_cyc = -1;

  // Requester drivers: present words from the source queue, hold until accepted.
  initial begin : drv_a
    logic fire;
    req_a_valid = 1'b0;
    req_a_data  = '0;
    forever begin
      @(negedge clk);
      fire = req_a_valid && req_a_ready;
      @(posedge clk); #1;
      if (fire) req_a_valid = 1'b0;
      if (!req_a_valid && src_a.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
        req_a_data  = src_a.pop_front();
        req_a_valid = 1'b1;
        if (a_rise_cyc < 0) a_rise_cyc = cyc;
      end
    end
  end

  initial begin : drv_b
    logic fire;
    req_b_valid = 1'b0;
    req_b_data  = '0;
    forever begin
      @(negedge clk);
      fire = req_b_valid && req_b_ready;
      @(posedge clk); #1;
      if (fire) req_b_valid = 1'b0;
      if (!req_b_valid && src_b.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
        req_b_data  = src_b.pop_front();
        req_b_valid = 1'b1;
      end
    end
  end

  initial begin : drv_out
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
      else out_ready = int'($urandom_range(99)) < ordy_pct;
    end
  end

  // Input side: push accepted words and enforce the burst hand-off rule.
  initial begin : sb_push
    int  streak_a, streak_b, side;
    bit  must_a, must_b;
    streak_a = 0; streak_b = 0; must_a = 0; must_b = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        streak_a = 0; streak_b = 0; must_a = 0; must_b = 0;
      end else begin
        if (!req_a_valid) streak_a = 0;
        if (!req_b_valid) streak_b = 0;
        chk("ready_exclusive", req_a_ready && req_b_ready, 0);
        side = 0;
        if (req_a_valid && req_a_ready) side = 1;
        if (req_b_valid && req_b_ready) side = 2;
        if (side != 0 && (must_a || must_b)) chk("handoff_side", side, must_b ? 2 : 1);
        if (side == 1) begin
          exp_q.push_back(req_a_data);
          must_a = 0; must_b = 0;
          streak_b = 0;
          streak_a++;
          if (streak_a % MAXB == 0 && req_b_valid) must_b = 1;
        end else if (side == 2) begin
          exp_q.push_back(req_b_data);
          must_a = 0; must_b = 0;
          streak_a = 0;
          streak_b++;
          if (streak_b % MAXB == 0 && req_a_valid) must_a = 1;
        end
      end
    end
  end

  // Output side: pop and compare on each accepted output beat.
  initial begin : sb_mon
    logic signed [BITS-1:0] held, e;
    bit was_stalled;
    was_stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        was_stalled = 0;
      end else begin
        if (was_stalled) begin
          chk("stall_valid_hold", out_valid, 1);
          chk("stall_data_hold", out_data, held);
        end
        chk("select_legal", (select == 3'sd2 || select == -3'sd2 || select == 3'sd0), 1);
        if (req_a_ready) chk("select_for_a", select, 2);
        if (req_b_ready) chk("select_for_b", select, -2);
        if (out_valid && !out_ready) chk("ready_while_stalled", req_a_ready || req_b_ready, 0);
        if (!out_valid) chk("idle_data_zero", out_data, 0);
        if (out_valid && out_ready) begin
          chk("sb_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e);
          end
          out_log.push_back(out_data);
          out_cyc.push_back(cyc);
        end
        was_stalled = out_valid && !out_ready;
        held = out_data;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((src_a.size() != 0 || src_b.size() != 0 || req_a_valid || req_b_valid ||
            exp_q.size() != 0 || out_valid) && k < budget) begin
      tick(1);
      k++;
    end
    chk("drain_in_budget", k < budget, 1);
  endtask

  // Arbitration order under continuous presentation: alternate bursts of up
  // to MAXB words, A first after reset, staying on a side whose rival is empty.
  task automatic model_order();
    bit on_b;
    on_b = 0;
    ord_q.delete();
    while (ma.size() + mb.size() > 0) begin
      if (on_b ? (mb.size() == 0) : (ma.size() == 0)) on_b = !on_b;
      for (int i = 0; i < MAXB; i++) begin
        if (on_b) begin
          if (mb.size() == 0) break;
          ord_q.push_back(mb.pop_front());
        end else begin
          if (ma.size() == 0) break;
          ord_q.push_back(ma.pop_front());
        end
      end
      if (on_b ? (ma.size() > 0) : (mb.size() > 0)) on_b = !on_b;
    end
  endtask

  task automatic check_order(input string name);
    chk({name, "_count"}, out_log.size(), ord_q.size());
    for (int i = 0; i < ord_q.size() && i < out_log.size(); i++)
      chk({name, "_word"}, out_log[i], ord_q[i]);
  endtask

  task automatic load_both_in_reset(input int na, input int nb, input int base_a, input int base_b);
    logic signed [BITS-1:0] v;
    rst = 1'b1;
    ma.delete(); mb.delete();
    for (int i = 0; i < na; i++) begin v = BITS'(base_a + i); ma.push_back(v); end
    for (int i = 0; i < nb; i++) begin v = BITS'(base_b - i); mb.push_back(v); end
    src_a = ma;
    src_b = mb;
    tick(2);
    out_log.delete(); out_cyc.delete();
    rst = 1'b0;
  endtask

  initial begin : main
    logic signed [BITS-1:0] v;
    logic [31:0] r;
    int k, na, nb;
    rst = 1'b1;

    // Reset held with both requesters presenting words.
    src_a.push_back(7'sd11);
    src_b.push_back(-7'sd11);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_select", select, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_ready_a", req_a_ready, 0);
      chk("rst_ready_b", req_b_ready, 0);
      @(posedge clk); #1;
    end
    out_log.delete(); out_cyc.delete();
    rst = 1'b0;
    wait_drain(100);
    chk("first_tie_count", out_log.size(), 2);
    if (out_log.size() > 0) chk("first_tie_to_a", out_log[0], 11);

    // Only A streams three words.
    rst = 1'b1; tick(2); rst = 1'b0;
    out_log.delete(); out_cyc.delete();
    a_rise_cyc = -1;
    src_a.push_back(7'sd5); src_a.push_back(-7'sd3); src_a.push_back(7'sd10);
    wait_drain(100);
    chk("onlya_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("onlya_w0", out_log[0], 5);
      chk("onlya_w1", out_log[1], -3);
      chk("onlya_w2", out_log[2], 10);
      chk("onlya_latency", out_cyc[0] - a_rise_cyc, 2);
      chk("onlya_back_to_back", out_cyc[2] - out_cyc[0], 2);
    end
    tick(2);
    @(negedge clk);
    chk("onlya_idle_select", select, 0);
    tick(1);

    // Continuous contention, no backpressure.
    load_both_in_reset(12, 12, 1, -1);
    model_order();
    wait_drain(200);
    check_order("contend");
    if (out_cyc.size() > 1) chk("contend_no_gaps", out_cyc[out_cyc.size()-1] - out_cyc[0], out_cyc.size() - 1);

    // Contention with a three-cycle stall inside the first A burst.
    load_both_in_reset(8, 4, 20, -20);
    stall_lo = cyc + 3;
    stall_hi = cyc + 5;
    model_order();
    wait_drain(200);
    check_order("stall");
    stall_lo = -1; stall_hi = -1;

    // Signed extremes pass bit-exact.
    rst = 1'b1; tick(2); rst = 1'b0;
    out_log.delete(); out_cyc.delete();
    src_a.push_back(7'sh40);
    wait_drain(100);
    src_b.push_back(7'sh3F);
    wait_drain(100);
    chk("extreme_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("extreme_min", out_log[0], -64);
      chk("extreme_max", out_log[1], 63);
    end

    // Reset in the middle of a B burst, then both request.
    rst = 1'b1; tick(2); rst = 1'b0;
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < 6; i++) begin v = BITS'(40 + i); src_b.push_back(v); end
    k = 0;
    while (out_log.size() < 2 && k < 100) begin tick(1); k++; end
    chk("midrst_burst_started", out_log.size() >= 2, 1);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("midrst_select", select, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_ready_a", req_a_ready, 0);
    chk("midrst_ready_b", req_b_ready, 0);
    src_a.push_back(7'sd33); src_a.push_back(7'sd34);
    tick(1);
    out_log.delete(); out_cyc.delete();
    rst = 1'b0;
    wait_drain(200);
    chk("midrst_has_output", out_log.size() > 0, 1);
    if (out_log.size() > 0) chk("midrst_a_first", out_log[0], 33);

    // Randomized traffic: gaps, backpressure, uneven loads.
    for (int round = 0; round < 12; round++) begin
      gap_pct  = int'($urandom_range(60));
      ordy_pct = 30 + int'($urandom_range(70));
      na = int'($urandom_range(10));
      nb = int'($urandom_range(10));
      for (int i = 0; i < na; i++) begin r = $urandom; v = r[BITS-1:0]; src_a.push_back(v); end
      if ($urandom_range(1) == 1) tick(int'($urandom_range(3)));
      for (int i = 0; i < nb; i++) begin r = $urandom; v = r[BITS-1:0]; src_b.push_back(v); end
      wait_drain(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
